vga_timing_gen: RTL and testbench

//   Produces the 640x480@60 raster timing (Xpixel/Ypixel/displayON plus HS/VS)

---
 rtl/vga_timing_gen.sv | 138 +++++++++++++
 tb/tb_vga_timing_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- 640x480@60 raster timing generator.
//   Divides CLK to a pixel strobe, walks Xpixel/Ypixel across the full
//   blanking interval and derives sync/display qualifiers from two phase FSMs.
// Ports:
//   CLK          system clock
//   reset_n      async active-low reset (sync release expected upstream)
//   Xpixel       horizontal count 0..H_TOTAL-1
//   Ypixel       vertical count 0..V_TOTAL-1
//   displayON    high inside the visible window
//   hsync/vsync  sync outputs, active level per HS_POL/VS_POL
//   pix_en       one-CLK pixel strobe; counters advance on the edge it is high
//   line_start   one-CLK pulse after Xpixel wraps to 0
//   frame_start  one-CLK pulse after (Xpixel,Ypixel) becomes (0,V_ACTIVE+1)
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic       CLK,
  input  logic       reset_n,
  output logic [9:0] Xpixel,
  output logic [9:0] Ypixel,
  output logic       displayON,
  output logic       hsync,
  output logic       vsync,
  output logic       pix_en,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_FP_S   = 10'(H_ACTIVE);
  localparam logic [9:0] H_SY_S   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BP_S   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_FP_S   = 10'(V_ACTIVE);
  localparam logic [9:0] V_SY_S   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_BP_S   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_FRAME  = 10'(V_ACTIVE + 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must fit a 10-bit counter");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV out of range 1..16");
  end

  typedef enum logic [1:0] {PH_ACT, PH_FP, PH_SYNC, PH_BP} phase_t;

  phase_t        h_state, h_nxt;
  phase_t        v_state, v_nxt;
  logic [DW-1:0] div, div_nxt;
  logic          pix_nxt;
  logic [9:0]    x_nxt, y_nxt;
  logic          hwrap;

  // Phase steps on the value the counter is about to take, so the FSM and
  // the counter land on the same edge and the outputs carry no skew.
  function automatic phase_t step(phase_t cur, logic [9:0] nxt,
                                  logic [9:0] fp_s, logic [9:0] sy_s,
                                  logic [9:0] bp_s);
    phase_t r;
    r = cur;
    if (nxt == 10'd0)     r = PH_ACT;
    else if (nxt == fp_s) r = PH_FP;
    else if (nxt == sy_s) r = PH_SYNC;
    else if (nxt == bp_s) r = PH_BP;
    return r;
  endfunction

  always_comb begin
    div_nxt = (div == DIV_LAST) ? '0 : div + DW'(1);
    // pix_en is registered: it is high in the cycle where div == CLK_DIV-1.
    // With CLK_DIV=1 div never moves, so it stays high after the first edge.
    pix_nxt = (div_nxt == DIV_LAST);
    x_nxt   = Xpixel;
    y_nxt   = Ypixel;
    h_nxt   = h_state;
    v_nxt   = v_state;
    hwrap   = 1'b0;
    if (pix_en) begin
      if (Xpixel == H_LAST) begin
        x_nxt = '0;
        hwrap = 1'b1;
        y_nxt = (Ypixel == V_LAST) ? '0 : Ypixel + 10'd1;
        v_nxt = step(v_state, y_nxt, V_FP_S, V_SY_S, V_BP_S);
      end else begin
        x_nxt = Xpixel + 10'd1;
      end
      h_nxt = step(h_state, x_nxt, H_FP_S, H_SY_S, H_BP_S);
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      div         <= '0;
      pix_en      <= 1'b0;
      Xpixel      <= '0;
      Ypixel      <= '0;
      h_state     <= PH_ACT;
      v_state     <= PH_ACT;
      displayON   <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= div_nxt;
      pix_en      <= pix_nxt;
      Xpixel      <= x_nxt;
      Ypixel      <= y_nxt;
      h_state     <= h_nxt;
      v_state     <= v_nxt;
      // Qualifiers come from next-state so they share the counters' edge.
      displayON   <= (h_nxt == PH_ACT) && (v_nxt == PH_ACT);
      hsync       <= (h_nxt == PH_SYNC) ? HS_POL : ~HS_POL;
      vsync       <= (v_nxt == PH_SYNC) ? VS_POL : ~VS_POL;
      // hwrap only fires with pix_en, so these cannot repeat while the
      // count holds between strobes.
      line_start  <= hwrap;
      frame_start <= hwrap && (y_nxt == V_FRAME);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst_a, rst_s;

  // Full-size 640x480 instance.
  logic [9:0] xa, ya;
  logic dea, hsa, vsa, pea, lsa, fsa;
  vga_timing_gen dut_a (
    .CLK(CLK), .reset_n(rst_a), .Xpixel(xa), .Ypixel(ya), .displayON(dea),
    .hsync(hsa), .vsync(vsa), .pix_en(pea), .line_start(lsa), .frame_start(fsa));

  // Small raster (15x13) so full frames fit in a short run.
  // H: act 0..7, fp 8..9, sync 10..12, bp 13..14; V: act 0..5, fp 6..7, sync 8..9, bp 10..12
  logic [9:0] xb, yb, xc, yc, xd, yd;
  logic deb, hsb, vsb, peb, lsb, fsb;
  logic dec, hsc, vsc, pec, lsc, fsc;
  logic ded, hsd, vsd, ped, lsd, fsd;

  vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)) dut_b (
    .CLK(CLK), .reset_n(rst_s), .Xpixel(xb), .Ypixel(yb), .displayON(deb),
    .hsync(hsb), .vsync(vsb), .pix_en(peb), .line_start(lsb), .frame_start(fsb));

  vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .HS_POL(1'b1), .VS_POL(1'b1)) dut_c (
    .CLK(CLK), .reset_n(rst_s), .Xpixel(xc), .Ypixel(yc), .displayON(dec),
    .hsync(hsc), .vsync(vsc), .pix_en(pec), .line_start(lsc), .frame_start(fsc));

  vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)) dut_d (
    .CLK(CLK), .reset_n(rst_s), .Xpixel(xd), .Ypixel(yd), .displayON(ded),
    .hsync(hsd), .vsync(vsd), .pix_en(ped), .line_start(lsd), .frame_start(fsd));

  int checks = 0;
  int failures = 0;

  task automatic cmp(input string name, input int n, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 20)
        $display("FAIL %s at edge %0d: got %h expected %h", name, n, got, exp);
    end
  endtask

  // Expected small-raster state n edges after reset release.
  // d=2: pixel advances on even edges. d=1: pix_en rises after edge 1,
  // so the pixel advances on every edge from edge 2 on.
  function automatic logic [25:0] model(input int n, input int d, input bit pol);
    int p, x, y;
    bit pe, ch, de, hs, vs, ls, fs;
    p  = (d == 2) ? n / 2 : ((n > 0) ? n - 1 : 0);
    x  = p % 15;
    y  = (p / 15) % 13;
    pe = (d == 2) ? (n % 2 == 1) : (n >= 1);
    ch = (d == 2) ? (n > 0 && n % 2 == 0) : (n >= 2);
    de = (n >= 1) && x < 8 && y < 6;
    hs = (x >= 10 && x <= 12) ? pol : ~pol;
    vs = (y >= 8 && y <= 9) ? pol : ~pol;
    ls = ch && x == 0;
    fs = ls && y == 7;
    return {10'(x), 10'(y), pe, de, hs, vs, ls, fs};
  endfunction

  task automatic check_small(input int n);
    cmp("small_div2", n, 32'({xb, yb, peb, deb, hsb, vsb, lsb, fsb}), 32'(model(n, 2, 1'b0)));
    cmp("small_pol1", n, 32'({xc, yc, pec, dec, hsc, vsc, lsc, fsc}), 32'(model(n, 2, 1'b1)));
    cmp("small_div1", n, 32'({xd, yd, ped, ded, hsd, vsd, lsd, fsd}), 32'(model(n, 1, 1'b0)));
  endtask

  typedef struct {
    int   cyc;
    int   x;
    int   y;
    logic pe;
    logic de;
    logic hs;
    logic ls;
  } vec_t;

  vec_t tbl[16];

  task automatic check_a(input vec_t v);
    cmp("a_x",  v.cyc, 32'(xa),  32'(v.x));
    cmp("a_y",  v.cyc, 32'(ya),  32'(v.y));
    cmp("a_pe", v.cyc, 32'(pea), 32'(v.pe));
    cmp("a_de", v.cyc, 32'(dea), 32'(v.de));
    cmp("a_hs", v.cyc, 32'(hsa), 32'(v.hs));
    cmp("a_ls", v.cyc, 32'(lsa), 32'(v.ls));
    cmp("a_vs", v.cyc, 32'(vsa), 32'd1);
    cmp("a_fs", v.cyc, 32'(fsa), 32'd0);
  endtask

  initial begin
    int hs_low, de_high, ls_cnt, fs_cnt, vs_low, vs_bad, de_bad;
    //          cyc    x    y  pe de hs ls
    tbl[0]  = '{0,     0,   0, 0, 0, 1, 0};
    tbl[1]  = '{1,     0,   0, 1, 1, 1, 0};
    tbl[2]  = '{2,     1,   0, 0, 1, 1, 0};
    tbl[3]  = '{3,     1,   0, 1, 1, 1, 0};
    tbl[4]  = '{1279,  639, 0, 1, 1, 1, 0};
    tbl[5]  = '{1280,  640, 0, 0, 0, 1, 0};
    tbl[6]  = '{1310,  655, 0, 0, 0, 1, 0};
    tbl[7]  = '{1312,  656, 0, 0, 0, 0, 0};
    tbl[8]  = '{1502,  751, 0, 0, 0, 0, 0};
    tbl[9]  = '{1504,  752, 0, 0, 0, 1, 0};
    tbl[10] = '{1598,  799, 0, 0, 0, 1, 0};
    tbl[11] = '{1599,  799, 0, 1, 0, 1, 0};
    tbl[12] = '{1600,  0,   1, 0, 1, 1, 1};
    tbl[13] = '{1601,  0,   1, 1, 1, 1, 0};
    tbl[14] = '{1602,  1,   1, 0, 1, 1, 0};
    tbl[15] = '{1603,  1,   1, 1, 1, 1, 0};

    hs_low = 0; de_high = 0; ls_cnt = 0; fs_cnt = 0;
    vs_low = 0; vs_bad = 0; de_bad = 0;

    rst_a = 1'b0;
    rst_s = 1'b0;
    repeat (3) @(negedge CLK);
    rst_a = 1'b1;
    rst_s = 1'b1;
    #1;
    check_a(tbl[0]);
    check_small(0);

    for (int n = 1; n <= 1610; n++) begin
      @(posedge CLK);
      @(negedge CLK);
      for (int i = 1; i < 16; i++)
        if (tbl[i].cyc == n) check_a(tbl[i]);
      if (n <= 1599) begin
        if (!hsa) hs_low++;
        if (dea)  de_high++;
      end
      if (lsa) ls_cnt++;
      if (n <= 400) check_small(n);
      if (n <= 390) begin
        if (fsb) begin
          fs_cnt++;
          cmp("fs_pos", n, 32'({xb, yb}), {12'd0, 10'd0, 10'd7});
        end
        if (!vsb) begin
          vs_low++;
          if (yb != 10'd8 && yb != 10'd9) vs_bad++;
        end
        if (deb && yb >= 10'd6) de_bad++;
      end
    end
    cmp("a_hs_low_clks", 1610, 32'(hs_low), 32'd192);
    cmp("a_de_high_clks", 1610, 32'(de_high), 32'd1279);
    cmp("a_line_starts", 1610, 32'(ls_cnt), 32'd1);
    cmp("b_frame_starts", 390, 32'(fs_cnt), 32'd1);
    cmp("b_vs_low_clks", 390, 32'(vs_low), 32'd60);
    cmp("b_vs_outside", 390, 32'(vs_bad), 32'd0);
    cmp("b_de_in_vblank", 390, 32'(de_bad), 32'd0);

    // Async reset mid-line on the full-size instance, between clock edges.
    #2 rst_a = 1'b0;
    #1;
    check_a(tbl[0]);

    // Restart the small instances and stop them inside both sync pulses
    // (pixel 132 -> x=12, y=8), then reset between edges.
    rst_s = 1'b0;
    @(negedge CLK);
    rst_s = 1'b1;
    #1 check_small(0);
    for (int n = 1; n <= 265; n++) begin
      @(posedge CLK);
      @(negedge CLK);
      check_small(n);
    end
    cmp("mid_hs_active", 265, 32'(hsb), 32'd0);
    cmp("mid_vs_active", 265, 32'(vsb), 32'd0);
    #2 rst_s = 1'b0;
    #1 check_small(0);
    cmp("mid_rst_hsc_inactive", 0, 32'(hsc), 32'd0);
    @(negedge CLK);
    check_small(0);
    rst_s = 1'b1;
    #1 check_small(0);
    for (int n = 1; n <= 40; n++) begin
      @(posedge CLK);
      @(negedge CLK);
      check_small(n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
